// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/MEM hazard inputs, stall/flush/forward controls out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [1:0]       id_uses;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic             mem_memread;
  logic [1:0]       pc_src_req;
  logic             mem_busy;

  logic [1:0]       Frwd1_ID;
  logic [1:0]       Frwd2_ID;
  logic [1:0]       pc_src;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             hold_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_memread, pc_src_req, mem_busy,
    input  Frwd1_ID, Frwd2_ID, pc_src, pc_en, if_id_en, if_id_flush,
           id_ex_bubble, hold_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_memread, pc_src_req, mem_busy,
    output Frwd1_ID, Frwd2_ID, pc_src, pc_en, if_id_en, if_id_flush,
           id_ex_bubble, hold_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: forwarding, load-use stall, redirect flush, memory-hold watchdog.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall/flush counters.
module hazard_ctrl #(
  parameter logic [7:0] HOLD_MAX = 8'd255,
  parameter int         CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [7:0] hold_cnt_q;
  logic [7:0] hold_cnt_d;
  logic       hold_timeout_q;
  logic       hold_timeout_d;

  logic       load_use;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic [1:0] pc_src;

  // Per-operand forwarding select and load-use detection; index 0 = rs, 1 = rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0] src;
      logic       used;
      logic       ex_hit;
      logic       mem_hit;
      logic       ld_hit;
      logic [1:0] sel;

      assign src     = (gi == 0) ? hz.id_rs : hz.id_rt;
      assign used    = hz.id_uses[gi];
      assign ex_hit  = used && (src != 5'd0) && (src == hz.ex_rd);
      assign mem_hit = used && (src != 5'd0) && (src == hz.mem_rd);
      assign ld_hit  = ex_hit && hz.ex_regwrite && hz.ex_memread;

      always_comb begin
        sel = 2'd0;
        if (ex_hit && hz.ex_regwrite && !hz.ex_memread) begin
          sel = 2'd1;
        end else if (mem_hit && hz.mem_regwrite) begin
          sel = hz.mem_memread ? 2'd3 : 2'd2;
        end
      end
    end
  endgenerate

  assign hz.Frwd1_ID = g_fwd[0].sel;
  assign hz.Frwd2_ID = g_fwd[1].sel;
  assign load_use    = g_fwd[0].ld_hit | g_fwd[1].ld_hit;

  // A frozen ID keeps presenting its redirect request, so gating it here defers rather than drops it.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_src       = 2'd0;
    if (hz.mem_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_src      = hz.pc_src_req;
      if_id_flush = (hz.pc_src_req != 2'd0);
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.pc_src       = pc_src;

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = 8'd0;
    hold_timeout_d = hold_timeout_q;
    case (state_q)
      RUN: begin
        if (hz.mem_busy) begin
          state_d    = HOLD;
          hold_cnt_d = 8'd1;
        end
      end
      HOLD: begin
        if (hz.mem_busy) begin
          hold_cnt_d = (hold_cnt_q >= HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 8'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (hz.mem_busy && (hold_cnt_d == HOLD_MAX)) begin
      hold_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      hold_cnt_q     <= 8'd0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  assign hz.hold_timeout = hold_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed scoreboard bench for hazard_ctrl, checked against a spec-level model.
// Driver pushes expectations at posedge+1; monitor pops and compares on each negedge.
module tb_hazard_ctrl;

  localparam int         CW = 4;
  localparam logic [7:0] HM = 8'd4;
  localparam int         CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] uses;
    logic [4:0] exrd;
    logic       exw;
    logic       exm;
    logic [4:0] mrd;
    logic       mw;
    logic       mm;
    logic [1:0] req;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic [1:0]    f1;
    logic [1:0]    f2;
    logic [1:0]    pcs;
    logic          pce;
    logic          ife;
    logic          flush;
    logic          bub;
    logic          to;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk;
  logic reset_n;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(
    .HOLD_MAX (HM),
    .CNT_W    (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    total;
  int    bad;
  int    txn;

  // Model state: consecutive busy edges, sticky watchdog, event counts.
  int    m_run;
  bit    m_to;
  int    m_sc;
  int    m_fc;
  stim_t cur;
  exp_t  cur_exp;

  function automatic logic [1:0] fwd_model(input logic [4:0] r, input logic u, input stim_t s);
    if (!u || r == 5'd0) return 2'd0;
    if (r == s.exrd && s.exw && !s.exm) return 2'd1;
    if (r == s.mrd && s.mw) return s.mm ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit   lu;
    lu = s.exm && s.exw && (s.exrd != 5'd0) &&
         ((s.uses[0] && s.rs == s.exrd) || (s.uses[1] && s.rt == s.exrd));
    e.f1 = fwd_model(s.rs, s.uses[0], s);
    e.f2 = fwd_model(s.rt, s.uses[1], s);
    if (s.busy) begin
      e.pce = 0; e.ife = 0; e.bub = 0; e.flush = 0; e.pcs = 2'd0;
    end else if (lu) begin
      e.pce = 0; e.ife = 0; e.bub = 1; e.flush = 0; e.pcs = 2'd0;
    end else begin
      e.pce = 1; e.ife = 1; e.bub = 0; e.pcs = s.req; e.flush = (s.req != 2'd0);
    end
    e.to = m_to;
`ifdef HAZARD_PERF_EN
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    return e;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk);
    if (cur.rst_n) begin
      if (cur.busy) begin
        if (m_run < int'(HM)) m_run++;
        if (m_run == int'(HM)) m_to = 1;
      end else begin
        m_run = 0;
      end
      if (!cur_exp.pce && m_sc < CNT_MAX) m_sc++;
      if (cur_exp.flush && m_fc < CNT_MAX) m_fc++;
    end
    #1;
    reset_n         = s.rst_n;
    hz.id_rs        = s.rs;
    hz.id_rt        = s.rt;
    hz.id_uses      = s.uses;
    hz.ex_rd        = s.exrd;
    hz.ex_regwrite  = s.exw;
    hz.ex_memread   = s.exm;
    hz.mem_rd       = s.mrd;
    hz.mem_regwrite = s.mw;
    hz.mem_memread  = s.mm;
    hz.pc_src_req   = s.req;
    hz.mem_busy     = s.busy;
    cur = s;
    if (!s.rst_n) begin
      m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end
    cur_exp = predict(s);
    exp_q.push_back(cur_exp);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL txn=%0d %s actual=%0h required=%0h", txn, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("Frwd1_ID",     8'(hz.Frwd1_ID),     8'(e.f1));
      chk("Frwd2_ID",     8'(hz.Frwd2_ID),     8'(e.f2));
      chk("pc_src",       8'(hz.pc_src),       8'(e.pcs));
      chk("pc_en",        8'(hz.pc_en),        8'(e.pce));
      chk("if_id_en",     8'(hz.if_id_en),     8'(e.ife));
      chk("if_id_flush",  8'(hz.if_id_flush),  8'(e.flush));
      chk("id_ex_bubble", 8'(hz.id_ex_bubble), 8'(e.bub));
      chk("hold_timeout", 8'(hz.hold_timeout), 8'(e.to));
      chk("stall_cnt",    8'(hz.stall_cnt),    8'(e.sc));
      chk("flush_cnt",    8'(hz.flush_cnt),    8'(e.fc));
      $display("txn %0d rst_n=%0b busy=%0b f1=%0d f2=%0d pc_en=%0b pc_src=%0d flush=%0b bub=%0b to=%0b sc=%0d fc=%0d",
               txn, reset_n, hz.mem_busy, hz.Frwd1_ID, hz.Frwd2_ID, hz.pc_en, hz.pc_src,
               hz.if_id_flush, hz.id_ex_bubble, hz.hold_timeout, hz.stall_cnt, hz.flush_cnt);
      txn++;
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  stim_t s;
  int    burst;

  initial begin
    total = 0; bad = 0; txn = 0;
    m_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    cur = '0; cur_exp = '0; burst = 0;
    reset_n = 1'b0;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses = '0; hz.ex_rd = '0;
    hz.ex_regwrite = 0; hz.ex_memread = 0; hz.mem_rd = '0;
    hz.mem_regwrite = 0; hz.mem_memread = 0; hz.pc_src_req = '0; hz.mem_busy = 0;

    s = idle(); s.rst_n = 0; apply(s); apply(s);

    // EX beats MEM for the same source; rt unused.
    s = idle(); s.exrd = 5; s.exw = 1; s.mrd = 5; s.mw = 1; s.rs = 5; s.rt = 5; s.uses = 2'b01; apply(s);

    // Load-use: one stall cycle, then the load sits in MEM.
    s = idle(); s.exrd = 7; s.exw = 1; s.exm = 1; s.rt = 7; s.uses = 2'b10; apply(s);
    s = idle(); s.mrd = 7; s.mw = 1; s.mm = 1; s.rt = 7; s.uses = 2'b10; apply(s);

    // Redirect with and without a load-use stall.
    s = idle(); s.req = 2; apply(s);
    s = idle(); s.req = 2; s.exrd = 3; s.exw = 1; s.exm = 1; s.rs = 3; s.uses = 2'b01; apply(s);
    s = idle(); s.req = 2; s.mrd = 3; s.mw = 1; s.mm = 1; s.rs = 3; s.uses = 2'b01; apply(s);

    // Watchdog: 3 busy cycles stay clear, 4 set it and it sticks.
    s = idle(); s.busy = 1; repeat (3) apply(s);
    s = idle(); apply(s);
    s = idle(); s.busy = 1; repeat (4) apply(s);
    s = idle(); repeat (2) apply(s);

    // Reset mid-hold: the hold restarts from zero afterwards.
    s = idle(); s.busy = 1; repeat (2) apply(s);
    s.rst_n = 0; apply(s);
    s = idle(); s.busy = 1; repeat (3) apply(s);
    s = idle(); repeat (2) apply(s);

    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 79) != 0);
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.uses  = 2'($urandom);
      s.exrd  = 5'($urandom_range(0, 3));
      s.exw   = 1'($urandom);
      s.exm   = 1'($urandom);
      s.mrd   = 5'($urandom_range(0, 3));
      s.mw    = 1'($urandom);
      s.mm    = 1'($urandom);
      s.req   = 2'($urandom);
      if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 6);
      s.busy = (burst != 0);
      if (burst != 0) burst--;
      apply(s);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter HOLD_MAX, 8'd255, consecutive mem_busy cycles that set hold_timeout; legal range 1..255.
REQ-002 Parameter CNT_W, 16, width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses  in  2  bit0: ID reads rs; bit1: ID reads rt.
REQ-007 ex_rd, ex_regwrite, ex_memread  in  5/1/1  destination, write enable and load flag of the EX instruction.
REQ-008 mem_rd, mem_regwrite, mem_memread  in  5/1/1  destination, write enable and load flag of the MEM instruction.
REQ-009 pc_src_req  in  2  decode redirect request: 0 plus4, 1 jump, 2 jr, 3 branch taken.
REQ-010 mem_busy  in  1  memory not ready; the whole pipeline SHALL freeze.
REQ-011 Frwd1_ID, Frwd2_ID  out  2 each  forwarding selects for rs/rt: 0 regfile, 1 ALUout1 (EX), 2 ALUout2 (MEM), 3 read_data (MEM load).
REQ-012 pc_src  out  2  PC mux select; pc_en  out  1  PC mux enable.
REQ-013 if_id_en, if_id_flush, id_ex_bubble  out  1 each  IF/ID hold, IF/ID clear, and ID/EX bubble insert.
REQ-014 hold_timeout  out  1  sticky watchdog flag.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 Register 0 SHALL never be a forwarding source; an operand is matched only when its id_uses bit is set.
REQ-017 Forwarding select, per operand, combinational, first match wins: EX match with ex_regwrite=1 and ex_memread=0 gives 1; MEM match with mem_regwrite=1 gives 3 if mem_memread=1, else 2; otherwise 0.
REQ-018 load_use SHALL be 1 when ex_memread=1, ex_regwrite=1, ex_rd!=0, and ex_rd matches a used ID source.
REQ-019 Priority SHALL be mem_busy > load_use > redirect, evaluated combinationally in the same cycle.
REQ-020 mem_busy=1: pc_en=0, if_id_en=0, id_ex_bubble=0, if_id_flush=0, pc_src=0.
REQ-021 load_use=1 with mem_busy=0: pc_en=0, if_id_en=0, id_ex_bubble=1, if_id_flush=0, pc_src=0. The stall lasts exactly one cycle, because the load then advances to MEM.
REQ-022 Otherwise: pc_en=1, if_id_en=1, pc_src=pc_src_req, and if_id_flush=1 iff pc_src_req!=0.
REQ-023 A redirect requested while stalled or held SHALL be deferred, not lost, because ID is frozen and the request persists.
REQ-024 FSM states RUN and HOLD; hold_cnt is an 8-bit register.
REQ-025 RUN->HOLD on an edge with mem_busy=1; HOLD->RUN on an edge with mem_busy=0.
REQ-026 hold_cnt SHALL increment on each edge with mem_busy=1, saturate at HOLD_MAX, and clear on an edge with mem_busy=0.
REQ-027 hold_timeout SHALL set on the edge where hold_cnt becomes HOLD_MAX and stay set until reset.

Reset
REQ-028 reset_n=0 SHALL immediately force state=RUN, hold_cnt=0, hold_timeout=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-029 Combinational outputs SHALL follow their inputs during reset; a hold in progress is abandoned and restarts counting from 0.

Configuration
REQ-030 Macro HAZARD_PERF_EN defined: on each edge, stall_cnt += 1 when pc_en=0 and flush_cnt += 1 when if_id_flush=1; both saturate at all-ones.
REQ-031 Macro HAZARD_PERF_EN undefined: no counter registers are built; stall_cnt and flush_cnt are tied to 0 and the ports remain.

Verification
REQ-032 Forwarding: ex_rd=5, ex_regwrite=1, ex_memread=0, mem_rd=5, mem_regwrite=1, id_rs=5, id_uses=01 -> Frwd1_ID=1 (EX wins), Frwd2_ID=0.
REQ-033 Load-use: ex_memread=1, ex_regwrite=1, ex_rd=7, id_rt=7, id_uses=10 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle mem_rd=7, mem_memread=1 -> Frwd2_ID=3, pc_en=1.
REQ-034 Redirect: pc_src_req=2 with no hazard -> pc_src=2, if_id_flush=1; same request with load_use -> pc_src=0, if_id_flush=0, then pc_src=2 in the following cycle.
REQ-035 Watchdog: HOLD_MAX=4, mem_busy=1 for 4 cycles -> hold_timeout=1 from the 5th cycle and remains 1 after mem_busy=0; with mem_busy=1 for 3 cycles -> hold_timeout stays 0.
REQ-036 Reset mid-hold: reset_n=0 asserted between edges during HOLD -> state=RUN, hold_cnt=0, counters=0 with no clock edge; with HAZARD_PERF_EN, 3 stall cycles -> stall_cnt=3.
